// File: rtl/dvp_byte_serializer.sv
// AXI-Stream RGB565 to OV5642-style 8-bit parallel video serializer with generated blanking.
// Optional colour-bar generator enabled by defining DVP_TEST_PATTERN_EN.
module dvp_byte_serializer #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int H_BLANK      = 16,
    parameter int VSYNC_CYCLES = 64,
    parameter int VBP_CYCLES   = 128
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [15:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    input  logic        s_tuser,
    output logic [7:0]  dvp_data,
    output logic        dvp_href,
    output logic        dvp_vsync,
    output logic        frame_done,
    output logic        underrun,
    output logic        sync_err
`ifdef DVP_TEST_PATTERN_EN
    ,
    input  logic        pattern_en
`endif
);

    localparam int PW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int LW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BMAX = (VSYNC_CYCLES > VBP_CYCLES) ?
                          ((VSYNC_CYCLES > H_BLANK) ? VSYNC_CYCLES : H_BLANK) :
                          ((VBP_CYCLES > H_BLANK) ? VBP_CYCLES : H_BLANK);
    localparam int BW   = $clog2(BMAX + 1);

    localparam logic [PW-1:0] PIX_LAST  = PW'(H_ACTIVE - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] VS_LAST   = BW'(VSYNC_CYCLES - 1);
    localparam logic [BW-1:0] VBP_LAST  = BW'(VBP_CYCLES - 1);
    localparam logic [BW-1:0] HB_LAST   = BW'(H_BLANK - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_VSYNC     = 3'd1,
        ST_VBP       = 3'd2,
        ST_ACTIVE    = 3'd3,
        ST_HBLANK    = 3'd4,
        ST_FRAME_END = 3'd5
    } state_t;

    state_t          state_r;
    logic            phase_r;
    logic [PW-1:0]   pix_cnt_r;
    logic [LW-1:0]   line_cnt_r;
    logic [BW-1:0]   blank_cnt_r;
    logic [7:0]      low_byte_r;
    logic            pattern_mode_r;

    logic            pattern_req_s;
    logic [15:0]     pattern_pix_s;
    logic            exp_last_s;
    logic            exp_first_s;
    logic            framing_err_s;

`ifdef DVP_TEST_PATTERN_EN
    localparam int BAR_PIX = H_ACTIVE / 8;

    function automatic logic [15:0] bar_color(input logic [2:0] bar);
        logic [15:0] color;
        case (bar)
            3'd0:    color = 16'hFFFF;
            3'd1:    color = 16'hFFE0;
            3'd2:    color = 16'h07FF;
            3'd3:    color = 16'h07E0;
            3'd4:    color = 16'hF81F;
            3'd5:    color = 16'hF800;
            3'd6:    color = 16'h001F;
            default: color = 16'h0000;
        endcase
        return color;
    endfunction

    logic [PW-1:0] bar_idx_s;

    // Colour-bar pixel for the current column
    always_comb begin
        bar_idx_s     = pix_cnt_r / PW'(BAR_PIX);
        pattern_req_s = pattern_en;
        pattern_pix_s = bar_color(bar_idx_s[2:0]);
    end
`else
    // Stream-only build: the pattern source never engages
    always_comb begin
        pattern_req_s = 1'b0;
        pattern_pix_s = 16'h0000;
    end
`endif

    // Framing expectation derived from the counters
    always_comb begin
        exp_last_s    = (pix_cnt_r == PIX_LAST);
        exp_first_s   = (pix_cnt_r == '0) && (line_cnt_r == '0);
        framing_err_s = (s_tlast != exp_last_s) || (s_tuser != exp_first_s);
    end

    // Ready: drain pre-frame words in IDLE, accept one word per pixel in ACTIVE
    always_comb begin
        s_tready = 1'b0;
        case (state_r)
            ST_IDLE:   s_tready = s_tvalid && !s_tuser && !pattern_req_s;
            ST_ACTIVE: s_tready = !phase_r && !pattern_mode_r;
            default:   s_tready = 1'b0;
        endcase
    end

    // Frame/line sequencer with registered video outputs
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            phase_r        <= 1'b0;
            pix_cnt_r      <= '0;
            line_cnt_r     <= '0;
            blank_cnt_r    <= '0;
            low_byte_r     <= 8'h00;
            pattern_mode_r <= 1'b0;
            dvp_data       <= 8'h00;
            dvp_href       <= 1'b0;
            dvp_vsync      <= 1'b0;
            frame_done     <= 1'b0;
            underrun       <= 1'b0;
            sync_err       <= 1'b0;
        end else begin
            dvp_href   <= 1'b0;
            dvp_vsync  <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            sync_err   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    blank_cnt_r <= '0;
                    phase_r     <= 1'b0;
                    pix_cnt_r   <= '0;
                    line_cnt_r  <= '0;
                    dvp_data    <= 8'h00;
                    if (pattern_req_s) begin
                        pattern_mode_r <= 1'b1;
                        state_r        <= ST_VSYNC;
                    end else if (s_tvalid && s_tuser) begin
                        pattern_mode_r <= 1'b0;
                        state_r        <= ST_VSYNC;
                    end else begin
                        pattern_mode_r <= 1'b0;
                    end
                end
                ST_VSYNC: begin
                    dvp_vsync <= 1'b1;
                    if (blank_cnt_r == VS_LAST) begin
                        blank_cnt_r <= '0;
                        state_r     <= ST_VBP;
                    end else begin
                        blank_cnt_r <= blank_cnt_r + BW'(1);
                    end
                end
                ST_VBP: begin
                    if (blank_cnt_r == VBP_LAST) begin
                        blank_cnt_r <= '0;
                        state_r     <= ST_ACTIVE;
                    end else begin
                        blank_cnt_r <= blank_cnt_r + BW'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (!phase_r) begin
                        if (pattern_mode_r) begin
                            dvp_data   <= pattern_pix_s[15:8];
                            low_byte_r <= pattern_pix_s[7:0];
                            dvp_href   <= 1'b1;
                            phase_r    <= 1'b1;
                        end else if (s_tvalid) begin
                            dvp_data   <= s_tdata[15:8];
                            low_byte_r <= s_tdata[7:0];
                            dvp_href   <= 1'b1;
                            phase_r    <= 1'b1;
                            sync_err   <= framing_err_s;
                        end else begin
                            // Starved byte slot: href drops, the pixel is sent later
                            underrun <= 1'b1;
                        end
                    end else begin
                        dvp_data <= low_byte_r;
                        dvp_href <= 1'b1;
                        phase_r  <= 1'b0;
                        if (pix_cnt_r == PIX_LAST) begin
                            pix_cnt_r   <= '0;
                            line_cnt_r  <= line_cnt_r + LW'(1);
                            blank_cnt_r <= '0;
                            if (line_cnt_r == LINE_LAST) begin
                                state_r <= ST_FRAME_END;
                            end else begin
                                state_r <= ST_HBLANK;
                            end
                        end else begin
                            pix_cnt_r <= pix_cnt_r + PW'(1);
                        end
                    end
                end
                ST_HBLANK: begin
                    if (blank_cnt_r == HB_LAST) begin
                        blank_cnt_r <= '0;
                        state_r     <= ST_ACTIVE;
                    end else begin
                        blank_cnt_r <= blank_cnt_r + BW'(1);
                    end
                end
                ST_FRAME_END: begin
                    frame_done     <= 1'b1;
                    line_cnt_r     <= '0;
                    pattern_mode_r <= 1'b0;
                    state_r        <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dvp_byte_serializer.sv
// Directed self-checking bench for dvp_byte_serializer (H_ACTIVE=8, V_ACTIVE=2 frame).
module tb_dvp_byte_serializer;

    logic        pclk;
    logic        rst_n;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic        s_tuser;
    logic [7:0]  dvp_data;
    logic        dvp_href;
    logic        dvp_vsync;
    logic        frame_done;
    logic        underrun;
    logic        sync_err;
`ifdef DVP_TEST_PATTERN_EN
    logic        pattern_en;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    dvp_byte_serializer #(
        .H_ACTIVE(8), .V_ACTIVE(2), .H_BLANK(3), .VSYNC_CYCLES(2), .VBP_CYCLES(2)
    ) dut (
        .pclk(pclk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .dvp_data(dvp_data), .dvp_href(dvp_href), .dvp_vsync(dvp_vsync),
        .frame_done(frame_done), .underrun(underrun), .sync_err(sync_err)
`ifdef DVP_TEST_PATTERN_EN
        , .pattern_en(pattern_en)
`endif
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Output recorder, sampled on the falling edge
    logic       mon_clr = 1'b1;
    int         cyc, vs_cnt, last_vs, first_href, last_href, hgap, href_cnt;
    int         uc, sc, fd_cnt, fd_cyc, both, rdy_cnt, cur_run;
    logic       href_prev;
    int         runs_q[$];
    logic [7:0] bytes_q[$];

    always @(negedge pclk) begin
        if (mon_clr) begin
            cyc <= 0; vs_cnt <= 0; last_vs <= -1; first_href <= -1; last_href <= -1;
            hgap <= -1; href_cnt <= 0; uc <= 0; sc <= 0; fd_cnt <= 0; fd_cyc <= -1;
            both <= 0; rdy_cnt <= 0; cur_run <= 0; href_prev <= 1'b0;
            runs_q.delete();
            bytes_q.delete();
        end else begin
            cyc       <= cyc + 1;
            href_prev <= dvp_href;
            if (dvp_vsync) begin
                vs_cnt  <= vs_cnt + 1;
                last_vs <= cyc;
            end
            if (dvp_href) begin
                bytes_q.push_back(dvp_data);
                href_cnt  <= href_cnt + 1;
                last_href <= cyc;
                cur_run   <= href_prev ? cur_run + 1 : 1;
                if (first_href < 0) first_href <= cyc;
                if (!href_prev && last_href >= 0) hgap <= cyc - last_href - 1;
            end else if (href_prev) begin
                runs_q.push_back(cur_run);
            end
            if (underrun) uc <= uc + 1;
            if (sync_err) sc <= sc + 1;
            if (frame_done) begin
                fd_cnt <= fd_cnt + 1;
                fd_cyc <= cyc;
            end
            if (dvp_vsync && dvp_href) both <= both + 1;
            if (s_tready) rdy_cnt <= rdy_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon_reset();
        mon_clr = 1'b1;
        @(negedge pclk); #1;
        mon_clr = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic send(input logic [15:0] d, input logic l, input logic u);
        int t;
        t = 0;
        s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
        @(negedge pclk);
        while (!s_tready && t < 500) begin
            @(negedge pclk);
            t++;
        end
        chk("accept", 32'(t < 500), 32'd1);
        @(posedge pclk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] base, input int n, input int tl_x,
                              input int tu_x, input int stall);
        for (int i = 0; i < n; i++) begin
            if (i == stall) begin
                repeat (5) @(posedge pclk);
                #1;
            end
            send(base + 16'(i), (i % 8 == 7) || (i == tl_x), (i == 0) || (i == tu_x));
        end
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (fd_cnt == 0 && t < 2000) begin
            @(negedge pclk); #1;
            t++;
        end
        chk(tag, 32'(t < 2000), 32'd1);
        repeat (3) @(posedge pclk);
        #1;
        chk({tag, "_pulse"}, 32'(fd_cnt), 32'd1);
    endtask

    task automatic check_bytes(input string tag, input logic [15:0] base);
        logic [15:0] w;
        logic [7:0]  e;
        chk({tag, "_nbytes"}, 32'(bytes_q.size()), 32'd32);
        for (int i = 0; i < bytes_q.size() && i < 32; i++) begin
            w = base + 16'(i / 2);
            e = (i % 2 == 0) ? w[15:8] : w[7:0];
            chk({tag, "_byte"}, 32'(bytes_q[i]), 32'(e));
        end
    endtask

    task automatic check_shape(input string tag, input int nruns);
        chk({tag, "_vs_len"}, 32'(vs_cnt), 32'd2);
        chk({tag, "_vbp_gap"}, 32'(first_href - last_vs - 1), 32'd2);
        chk({tag, "_href_cnt"}, 32'(href_cnt), 32'd32);
        chk({tag, "_nruns"}, 32'(runs_q.size()), 32'(nruns));
        chk({tag, "_hblank"}, 32'(hgap), 32'd3);
        chk({tag, "_done_pos"}, 32'(fd_cyc), 32'(last_href + 1));
        chk({tag, "_vs_href"}, 32'(both), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; s_tdata = 16'h0000; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
`ifdef DVP_TEST_PATTERN_EN
        pattern_en = 1'b0;
`endif
        #12;
        chk("rst_data", 32'(dvp_data), 32'd0);
        chk("rst_href", 32'(dvp_href), 32'd0);
        chk("rst_vsync", 32'(dvp_vsync), 32'd0);
        chk("rst_pulses", 32'({frame_done, underrun, sync_err}), 32'd0);
        chk("rst_ready", 32'(s_tready), 32'd0);
        @(negedge pclk);
        rst_n = 1'b1;
        @(posedge pclk); #1;

        // Pre-frame garbage then a nominal frame
        mon_reset();
        for (int i = 0; i < 3; i++) send(16'hDEAD, 1'b0, 1'b0);
        chk("garbage_vsync", 32'(vs_cnt), 32'd0);
        chk("garbage_href", 32'(href_cnt), 32'd0);
        send_frame(16'h1234, 16, -1, -1, -1);
        wait_done("nom_done");
        check_shape("nom", 2);
        if (runs_q.size() == 2) begin
            chk("nom_run0", 32'(runs_q[0]), 32'd16);
            chk("nom_run1", 32'(runs_q[1]), 32'd16);
        end
        chk("nom_underrun", 32'(uc), 32'd0);
        chk("nom_sync_err", 32'(sc), 32'd0);
        check_bytes("nom", 16'h1234);

        // Underrun before pixel 3
        mon_reset();
        send_frame(16'h2000, 16, -1, -1, 3);
        wait_done("ur_done");
        check_shape("ur", 3);
        if (runs_q.size() == 3) begin
            chk("ur_run0", 32'(runs_q[0]), 32'd6);
            chk("ur_run1", 32'(runs_q[1]), 32'd10);
        end
        chk("ur_underrun", 32'(uc), 32'd4);
        chk("ur_sync_err", 32'(sc), 32'd0);
        check_bytes("ur", 16'h2000);

        // Framing errors: extra tlast on pixel 5, extra tuser on pixel 2
        mon_reset();
        send_frame(16'h3100, 16, 5, 2, -1);
        wait_done("se_done");
        check_shape("se", 2);
        chk("se_sync_err", 32'(sc), 32'd2);
        chk("se_underrun", 32'(uc), 32'd0);
        check_bytes("se", 16'h3100);

        // Asynchronous reset at pixel 4 of line 1
        mon_reset();
        send_frame(16'h7788, 13, -1, -1, -1);
        chk("prerst_href", 32'(dvp_href), 32'd1);
        chk("prerst_data", 32'(dvp_data), 32'h77);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_href", 32'(dvp_href), 32'd0);
        chk("arst_data", 32'(dvp_data), 32'd0);
        chk("arst_vsync", 32'(dvp_vsync), 32'd0);
        @(negedge pclk);
        rst_n = 1'b1;
        @(posedge pclk); #1;
        mon_reset();
        send_frame(16'hA000, 16, -1, -1, -1);
        wait_done("rr_done");
        check_shape("rr", 2);
        chk("rr_sync_err", 32'(sc), 32'd0);
        check_bytes("rr", 16'hA000);

`ifdef DVP_TEST_PATTERN_EN
        begin
            logic [7:0] pat [16];
            int t;
            pat = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                    8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
            mon_reset();
            pattern_en = 1'b1;
            t = 0;
            while (vs_cnt == 0 && t < 100) begin
                @(negedge pclk); #1;
                t++;
            end
            pattern_en = 1'b0;
            wait_done("pat_done");
            check_shape("pat", 2);
            chk("pat_ready", 32'(rdy_cnt), 32'd0);
            chk("pat_underrun", 32'(uc), 32'd0);
            chk("pat_sync_err", 32'(sc), 32'd0);
            chk("pat_nbytes", 32'(bytes_q.size()), 32'd32);
            for (int i = 0; i < bytes_q.size() && i < 32; i++)
                chk("pat_byte", 32'(bytes_q[i]), 32'(pat[i % 16]));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
